tone_decoder: RTL and testbench

//  Receive-side counterpart of the buzzer tone generator. Measures the period of an incoming

---
 rtl/tone_pkg.sv | 42 ++++
 rtl/tone_period_meter.sv | 47 ++++
 rtl/tone_decoder.sv | 107 ++++++++++
 tb/tb_tone_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared note-period table, widths and FSM encoding for the tone generator and decoder.
package tone_pkg;

  localparam int unsigned CNT_W     = 24;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NUM_NOTES = 7;

  localparam logic [IDX_W-1:0] NOTE_NONE = 3'd7;

  typedef logic [0:NUM_NOTES-1][CNT_W-1:0] note_table_t;

  // Period in clks of C4..B4 at 50 MHz (generator terminal count + 1).
  localparam note_table_t NOTE_PERIOD = '{
    24'd190840, 24'd170068, 24'd151515, 24'd143266,
    24'd127551, 24'd113636, 24'd101214
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Lowest note whose period lies within tbl[k] >> tol_shift of p; NOTE_NONE otherwise.
  function automatic logic [IDX_W-1:0] classify(input logic [CNT_W-1:0] p,
                                                input note_table_t     tbl,
                                                input int unsigned     tol_shift);
    logic [IDX_W-1:0] m;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] diff;
    m = NOTE_NONE;
    for (int unsigned k = 0; k < NUM_NOTES; k++) begin
      idx  = IDX_W'(k);
      diff = (p > tbl[idx]) ? (p - tbl[idx]) : (tbl[idx] - p);
      if ((m == NOTE_NONE) && (diff <= (tbl[idx] >> tol_shift))) begin
        m = idx;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises tone_in, strobes its rising edges and measures the clks between them.
module tone_period_meter
  import tone_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 24'd500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             edge_c,
  output logic [CNT_W-1:0] period_c,
  output logic             timeout_c
);

  logic             sync1;
  logic             sync2;
  logic             tone_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      tone_prev <= 1'b0;
    end else begin
      sync1     <= tone_in;
      sync2     <= sync1;
      tone_prev <= sync2;
    end
  end

  // Counter restarts on each edge and parks at TIMEOUT during silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (edge_c) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign edge_c    = sync2 & ~tone_prev;
  assign period_c  = cnt + CNT_W'(1);
  assign timeout_c = (cnt == TIMEOUT);

endmodule

// File: rtl/tone_decoder.sv
// Classifies the measured tone period against the note table and locks onto a stable note.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned      TOL_SHIFT  = 6,
  parameter int unsigned      MIN_CYCLES = 4,
  parameter logic [CNT_W-1:0] TIMEOUT    = 24'd500000,
  parameter note_table_t      NOTE_TABLE = NOTE_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [IDX_W-1:0] note_idx,
  output logic             note_new,
  output logic [CNT_W-1:0] period_out
);

  localparam int unsigned     MC_W   = $clog2(MIN_CYCLES + 1);
  localparam logic [MC_W-1:0] MC_MAX = MC_W'(MIN_CYCLES);

  logic             edge_c;
  logic [CNT_W-1:0] period_c;
  logic             timeout_c;

  state_t           state;
  logic [IDX_W-1:0] cand;
  logic [MC_W-1:0]  match_cnt;

  logic [IDX_W-1:0] m_c;
  logic [MC_W-1:0]  acq_cnt_c;

  tone_period_meter #(
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .tone_in  (tone_in),
    .edge_c   (edge_c),
    .period_c (period_c),
    .timeout_c(timeout_c)
  );

  // Classification of the current period and the resulting acquisition run length.
  always_comb begin
    m_c       = classify(period_c, NOTE_TABLE, TOL_SHIFT);
    acq_cnt_c = MC_W'(m_c != NOTE_NONE);
    if ((m_c == cand) && (m_c != NOTE_NONE)) begin
      acq_cnt_c = (match_cnt == MC_MAX) ? match_cnt : (match_cnt + MC_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cand       <= NOTE_NONE;
      match_cnt  <= '0;
      note_valid <= 1'b0;
      note_idx   <= NOTE_NONE;
      note_new   <= 1'b0;
      period_out <= '0;
    end else begin
      note_new <= 1'b0;
      if (timeout_c) begin
        // A coincident edge is the first edge of a fresh measurement, not a period.
        state      <= edge_c ? ST_ACQUIRE : ST_IDLE;
        cand       <= NOTE_NONE;
        match_cnt  <= '0;
        note_valid <= 1'b0;
        note_idx   <= NOTE_NONE;
      end else if (edge_c) begin
        case (state)
          ST_IDLE: begin
            state     <= ST_ACQUIRE;
            cand      <= NOTE_NONE;
            match_cnt <= '0;
          end
          ST_ACQUIRE: begin
            period_out <= period_c;
            cand       <= m_c;
            match_cnt  <= acq_cnt_c;
            if (acq_cnt_c == MC_MAX) begin
              state      <= ST_LOCKED;
              note_valid <= 1'b1;
              note_idx   <= m_c;
              note_new   <= 1'b1;
            end
          end
          ST_LOCKED: begin
            period_out <= period_c;
            if (m_c != note_idx) begin
              state      <= ST_ACQUIRE;
              note_valid <= 1'b0;
              note_idx   <= NOTE_NONE;
              cand       <= m_c;
              match_cnt  <= MC_W'(m_c != NOTE_NONE);
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder using a scaled-down note table to keep runs short.
module tb_tone_decoder;
  import tone_pkg::*;

  localparam int TOL_SH = 6;
  localparam int MIN_C  = 4;
  localparam int TMO    = 500;
  localparam note_table_t TB_TABLE = '{
    24'd372, 24'd332, 24'd295, 24'd279, 24'd249, 24'd221, 24'd197
  };
  localparam int REF_T [7] = '{372, 332, 295, 279, 249, 221, 197};
  localparam int KIND_LOCK   = 0;
  localparam int KIND_UNLOCK = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic        note_new;
  logic [23:0] period_out;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    int period;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;

  // Reference model state: event-level view of lock behaviour.
  int  last_rise = -1;
  bit  timed_out = 1'b0;
  bit  locked = 1'b0;
  int  lock_idx = 7;
  int  run_note = 7;
  int  run_len = 0;
  int  last_meas = 0;
  bit  prev_valid = 1'b0;

  tone_decoder #(
    .TOL_SHIFT (TOL_SH),
    .MIN_CYCLES(MIN_C),
    .TIMEOUT   (24'(TMO)),
    .NOTE_TABLE(TB_TABLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .note_valid(note_valid),
    .note_idx  (note_idx),
    .note_new  (note_new),
    .period_out(period_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int classify_ref(input int p);
    int d;
    for (int k = 0; k < 7; k++) begin
      d = (p > REF_T[k]) ? (p - REF_T[k]) : (REF_T[k] - p);
      if (d <= REF_T[k] / 64) return k;
    end
    return 7;
  endfunction

  task automatic push_ev(input int kind, input int c, input int idx, input int p);
    ev_t e;
    e.kind   = kind;
    e.cyc    = c;
    e.idx    = idx;
    e.period = p;
    exp_q.push_back(e);
  endtask

  // A rising edge of tone_in at cycle c; outputs react 3 clks later.
  task automatic model_rise(input int c);
    int p;
    int m;
    if (last_rise < 0 || timed_out) begin
      run_note = 7;
      run_len  = 0;
    end else begin
      p         = c - last_rise;
      last_meas = p;
      m         = classify_ref(p);
      if (locked) begin
        if (m != lock_idx) begin
          locked   = 1'b0;
          lock_idx = 7;
          push_ev(KIND_UNLOCK, c + 3, 7, p);
          run_note = m;
          run_len  = (m != 7) ? 1 : 0;
        end
      end else begin
        if (m != 7 && m == run_note) begin
          if (run_len < MIN_C) run_len++;
        end else begin
          run_note = m;
          run_len  = (m != 7) ? 1 : 0;
        end
        if (run_len == MIN_C) begin
          locked   = 1'b1;
          lock_idx = m;
          push_ev(KIND_LOCK, c + 3, m, p);
        end
      end
    end
    last_rise = c;
    timed_out = 1'b0;
  endtask

  // Gap of p clks after the rise at cycle c: longer than TMO means silence detected.
  task automatic model_gap(input int c, input int p);
    if (p > TMO) begin
      if (locked) push_ev(KIND_UNLOCK, c + TMO + 4, 7, last_meas);
      locked    = 1'b0;
      lock_idx  = 7;
      timed_out = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int p);
    tone_in = 1'b1;
    model_rise(cyc);
    model_gap(cyc, p);
    repeat (p / 2) tick();
    tone_in = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic run(input int note, input int off, input int n);
    repeat (n) pulse(REF_T[note] + off);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(note_valid), 0);
    check("async_rst_idx", int'(note_idx), 7);
    check("async_rst_new", int'(note_new), 0);
    check("async_rst_period", int'(period_out), 0);
    repeat (3) tick();
    rst       = 1'b0;
    last_rise = -1;
    timed_out = 1'b0;
    locked    = 1'b0;
    lock_idx  = 7;
    last_meas = 0;
    repeat (4) tick();
  endtask

  // Monitor: pops an expected event whenever the DUT locks or drops lock.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      check("rst_valid", int'(note_valid), 0);
      check("rst_idx", int'(note_idx), 7);
      check("rst_new", int'(note_new), 0);
      check("rst_period", int'(period_out), 0);
      prev_valid = 1'b0;
    end else begin
      if (!prev_valid && note_valid) check("lock_pulse", int'(note_new), 1);
      if (note_new) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lock", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("lock_kind", KIND_LOCK, e.kind);
          check("lock_cycle", cyc, e.cyc);
          check("lock_idx", int'(note_idx), e.idx);
          check("lock_period", int'(period_out), e.period);
          check("lock_valid", int'(note_valid), 1);
        end
      end
      if (prev_valid && !note_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_unlock", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("unlock_kind", KIND_UNLOCK, e.kind);
          check("unlock_cycle", cyc, e.cyc);
          check("unlock_idx", int'(note_idx), 7);
          check("unlock_period", int'(period_out), e.period);
        end
      end
      prev_valid = note_valid;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int sel;
    int note;
    int tol;
    int len;
    int off;

    // Reset held while the input toggles.
    repeat (40) begin
      tick();
      if (cyc % 4 == 0) tone_in = ~tone_in;
    end
    tone_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Basic lock on note 2, then asynchronous reset while locked.
    run(2, 0, 6);
    mid_reset();

    // Tolerance boundary: +4 locks, +5 does not, -4 relocks.
    run(2, 4, 6);
    run(2, 5, 6);
    run(2, -4, 5);

    // Note change 0 -> 6.
    run(0, 0, 6);
    run(6, 0, 5);

    // Period just below timeout, exactly at timeout, and long silence.
    run(3, 0, 5);
    pulse(TMO);
    run(3, 0, 5);
    pulse(TMO + 1);
    run(3, 0, 5);
    pulse(TMO + 300);
    run(1, 0, 5);

    // Stepped notes separated by a truncated boundary period.
    for (int n = 0; n < 7; n++) begin
      run(n, 0, 5);
      pulse(100 + int'($urandom_range(0, 80)));
    end

    // Randomized segments.
    for (int s = 0; s < 10; s++) begin
      sel  = int'($urandom_range(0, 9));
      note = int'($urandom_range(0, 6));
      tol  = REF_T[note] / 64;
      len  = int'($urandom_range(1, 7));
      if (sel < 6) begin
        for (int i = 0; i < len; i++) begin
          off = int'($urandom_range(0, 2 * tol)) - tol;
          pulse(REF_T[note] + off);
        end
      end else if (sel == 6) begin
        pulse(REF_T[note] + tol + 1 + int'($urandom_range(0, 3)));
      end else if (sel == 7) begin
        pulse(REF_T[note] - tol - 1 - int'($urandom_range(0, 3)));
      end else begin
        pulse(int'($urandom_range(150, TMO + 40)));
      end
    end

    pulse(TMO + 50);
    repeat (10) tick();
    check("pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
